apb_requester: RTL

APB requester that drives the `apb` register slave: the peripheral-facing end of the I2C controller's register bus. It accepts one command at a time on a valid/ready command port and runs the APB SETUP and ACCESS phases on PSELx/PENABLE/PWRITE/PADDR/PWDATA. It honours PREADY wait states, aborts stalled transfers with a wait-state timeout, and returns read data or a timeout flag on a one-cycle response strobe. It is used by the system-side sequencer and by the block-level bench as the bus driver for the `apb` slave.

---
 rtl/apb_requester.sv | 99 +++++++++
 1 files changed

// File: rtl/apb_requester.sv
// APB requester: one command at a time through SETUP/ACCESS with PREADY wait states,
// an optional wait-state timeout and a one-cycle response strobe.
module apb_requester #(
  parameter int TIMEOUT = 16
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_timeout,
  output logic       busy,
  output logic       PSELx,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [6:0] PADDR,
  output logic [7:0] PWDATA,
  input  logic       PREADY,
  input  logic [7:0] PRDATA
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] WAIT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam logic [CW-1:0] WAIT_MAX  = '1;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

  state_t        r_state, w_state_nx;
  logic [CW-1:0] r_wait;
  logic          w_done, w_abort;

  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);

  always_comb begin
    w_done     = 1'b0;
    w_abort    = 1'b0;
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:   if (cmd_valid) w_state_nx = S_SETUP;
      S_SETUP:  w_state_nx = S_ACCESS;
      S_ACCESS: begin
        w_done  = PREADY;
        // r_wait counts completed low cycles, so it equals TIMEOUT-1 during the last allowed one
        w_abort = (TIMEOUT != 0) && !PREADY && (r_wait == WAIT_LAST);
        if (w_done || w_abort) w_state_nx = S_IDLE;
      end
      default:  w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state     <= S_IDLE;
      r_wait      <= '0;
      PSELx       <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      rsp_valid <= w_done || w_abort;
      if (w_done || w_abort) begin
        rsp_timeout <= w_abort;
        rsp_rdata   <= (w_done && !PWRITE) ? PRDATA : 8'h00;
      end
      case (r_state)
        S_IDLE: if (cmd_valid) begin
          PSELx  <= 1'b1;
          PWRITE <= cmd_write;
          PADDR  <= cmd_addr;
          PWDATA <= cmd_write ? cmd_wdata : 8'h00;
        end
        S_SETUP: begin
          PENABLE <= 1'b1;
          r_wait  <= '0;
        end
        S_ACCESS: begin
          if (w_done || w_abort) begin
            PSELx   <= 1'b0;
            PENABLE <= 1'b0;
          end else if (r_wait != WAIT_MAX) begin
            r_wait <= r_wait + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
